fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage for the 16-bit CPU. It holds the PC and issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake. Fetched instructions are buffered in a 2-entry queue toward decode. It consumes the branch/jump redirect produced by the execute stage (take_branch_or_jump, new_PC), flushing wrong-path work, and stops fetching on HALT.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
BUF_DEPTH, 2, instruction buffer entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect  in  1  execute-stage take_branch_or_jump
redirect_pc  in  16  execute-stage new_PC, valid when redirect=1
imem_req  out  1  fetch request valid
imem_addr  out  16  request address (= pc)
imem_gnt  in  1  memory accepts request this cycle (req & gnt = handshake)
imem_rvalid  in  1  response valid, earliest cycle after grant
imem_rdata  in  16  response instruction
if_valid  out  1  buffer head valid
if_instr  out  16  head instruction
if_pc  out  16  head instruction address
if_incPC  out  16  if_pc + 2, feeds execute incrementPC
if_ready  in  1  decode accepts head (if_valid & if_ready = pop)
halted  out  1  HALT fetched; fetching stopped

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, buffer empty, drop=0, halted=0; imem_req=0, if_valid=0.
- States: IDLE, FETCH, WAIT, HALT.
- IDLE -> FETCH unconditionally one cycle after reset release.
- FETCH: imem_req=1 iff buffer count < 2; imem_addr=pc. On req&gnt: pc<=pc+2 (mod 2^16, 16'hFFFE wraps to 16'h0000), ->WAIT.
- WAIT: imem_req=0. On rvalid with drop=1: discard, drop<=0, ->FETCH. On rvalid with drop=0: enqueue {rdata, addr of request}; if rdata[15:11]==5'b00000 (HALT) ->HALT, else ->FETCH.
- HALT: imem_req=0, halted=1; buffer still drains to decode.
- Only one outstanding request; the request gate (count<2 counting the in-flight slot: count+inflight<2) guarantees enqueue never hits a full buffer.
- Buffer: registered; if_valid rises the cycle after the accepted rvalid (grant at t, rvalid at t+1 earliest, if_valid at t+2). Simultaneous push and pop allowed; count unchanged. Pop on empty ignored.
- Redirect (highest priority, any state except IDLE): buffer flushed same edge; pc<=redirect_pc; halted<=0.
  - In FETCH with req&gnt same cycle: grant counts, drop<=1, ->WAIT.
  - In FETCH without grant: ->FETCH.
  - In WAIT with no rvalid this cycle: drop<=1, stay WAIT.
  - In WAIT with rvalid same cycle: response discarded, drop stays 0, ->FETCH.
  - In HALT: ->FETCH (wrong-path HALT cancelled).
- Pop and redirect in the same cycle: flush wins; the popped head is still valid to decode that cycle.
- Reset mid-transaction: all state cleared; a late rvalid arriving in IDLE is ignored.

Decomposition:
- Shared package: OP_HALT=5'b00000, fetch state encoding (IDLE/FETCH/WAIT/HALT), RESET_PC default, 16-bit word width.
- Sub-module fetch_buffer: 2-entry FIFO of {instr[15:0], pc[15:0]} with push, pop, flush, count[1:0], head outputs; fetch_unit holds FSM, pc, drop flag.

Test Plan:
- Reset release, memory grants immediately, rvalid next cycle, if_ready=1: addresses 0000,0002,0004 requested; if_pc sequence 0000,0002,0004 with if_incPC 0002,0004,0006.
- if_ready=0 held: exactly two instructions buffered, imem_req drops to 0, count=2; raise if_ready -> fetching resumes at pc=0004.
- Redirect to 16'h0040 while in WAIT, rvalid two cycles later with 16'h1234: 1234 never appears on if_instr; next request address 0040.
- Redirect coincident with rvalid in WAIT: response dropped, no drop flag left, next request 0040 and its response delivered.
- rdata=16'h0000 at pc 0006: enqueued, halted=1, no further imem_req; later redirect to 0100 clears halted and fetches 0100.
- pc=FFFE fetch: next request address 0000; rst_n pulsed low mid-WAIT -> if_valid=0, pc=0000, stray rvalid ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int          WORD_W       = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [4:0]  OP_HALT      = 5'b00000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [WORD_W-1:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue between fetch and decode.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop     = pop && (count != 2'd0);
    assign do_push    = push && ((count != 2'd2) || do_pop);
    assign head_valid = (count != 2'd0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem handshake, redirect and HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_incPC,
    input  logic        if_ready,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t state_n;
    logic [15:0]  pc;
    logic [15:0]  pc_n;
    logic [15:0]  req_pc;
    logic [15:0]  req_pc_n;
    logic         drop;
    logic         drop_n;
    logic         push;
    logic         flush;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_data;

    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign if_incPC  = head.pc + 16'd2;
    assign flush     = redirect && (state != S_IDLE);

    assign push_data.instr = imem_rdata;
    assign push_data.pc    = req_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            drop   <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            req_pc <= req_pc_n;
            drop   <= drop_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        drop_n   = drop;
        push     = 1'b0;
        imem_req = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                // No in-flight slot here, so the gate is just count
                imem_req = int'(count) < BUF_DEPTH;
                if (imem_req && imem_gnt) begin
                    pc_n     = pc + 16'd2;
                    req_pc_n = pc;
                    state_n  = S_WAIT;
                end
                if (redirect) begin
                    pc_n   = redirect_pc;
                    drop_n = imem_req && imem_gnt;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_n = S_FETCH;
                    drop_n  = 1'b0;
                    if (!drop && !redirect) begin
                        push = 1'b1;
                        if (is_halt(imem_rdata)) begin
                            state_n = S_HALT;
                        end
                    end
                end
                if (redirect) begin
                    pc_n = redirect_pc;
                    if (!imem_rvalid) begin
                        drop_n = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (if_ready),
        .flush     (flush),
        .count     (count),
        .head_valid(if_valid),
        .head      (head)
    );

endmodule
